// File: rtl/cpu_pkg.sv
// Shared fetch-unit types: FSM state encoding, fault codes, NOP word and the redirect payload.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    FC_NONE        = 2'b00,
    FC_ACK_TIMEOUT = 2'b01,
    FC_MISALIGN    = 2'b10
  } fault_cause_e;

  // Control-flow information presented by the execute stage at retire.
  typedef struct packed {
    logic            pc_src;
    logic            jump_src;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_target;
  } redirect_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux (sequential / branch / JALR) with word-alignment check.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4_i,
  input  redirect_t       redir_i,
  output logic [XLEN-1:0] next_pc_c,
  output logic            misaligned_c
);

  always_comb begin
    next_pc_c = pc_plus4_i;
    if (redir_i.pc_src) begin
      // JALR drops bit 0 before the alignment check, so only bit 1 can fault it.
      next_pc_c = redir_i.jump_src ? (redir_i.jalr_target & ~XLEN'(1))
                                   : redir_i.branch_target;
    end
  end

  assign misaligned_c = |next_pc_c[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: BOOT/FETCH/HOLD/FAULT FSM, ack timeout counter,
// and PC/instruction registers handed to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic        JumpSrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  fault_cause_e     cause_q, cause_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;

  redirect_t        redir_c;
  logic [XLEN-1:0]  next_pc_c;
  logic             misaligned_c;

  always_comb begin
    redir_c.pc_src        = PCSrc;
    redir_c.jump_src      = JumpSrc;
    redir_c.branch_target = branch_target;
    redir_c.jalr_target   = jalr_target;
  end

  next_pc_sel u_next_pc_sel (
    .pc_plus4_i   (pc_plus4_q),
    .redir_i      (redir_c),
    .next_pc_c    (next_pc_c),
    .misaligned_c (misaligned_c)
  );

  // Next-state, counter and datapath updates; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FAULT;
          cause_d = FC_ACK_TIMEOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (retire) begin
          if (misaligned_c) begin
            state_d = ST_FAULT;
            cause_d = FC_MISALIGN;
          end else begin
            pc_d    = next_pc_c;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    pc_plus4_d = pc_d + XLEN'(4);
    req_d      = (state_d == ST_FETCH);
    valid_d    = (state_d == ST_HOLD);
    fault_d    = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      cause_q    <= FC_NONE;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + XLEN'(4);
      instr_q    <= NOP_INSTR;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized fetch/retire traffic
// checked against a transaction-level model of PC, instruction and fault status.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int unsigned ACK_TIMEOUT = 16;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc, JumpSrc, retire;
  logic [31:0] branch_target, jalr_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, fault;
  logic [1:0]  fault_cause;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_fault;
  logic [1:0]  m_cause;

  fetch_unit #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .PCSrc         (PCSrc),
    .JumpSrc       (JumpSrc),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .retire        (retire),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fault         (fault),
    .fault_cause   (fault_cause)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, instr, m_instr);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_pc4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  task automatic check_fault(input string tag);
    chk({tag, "_fault"}, 32'(fault), 32'd1);
    chk({tag, "_cause"}, 32'(fault_cause), 32'(m_cause));
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_pc"}, pc, m_pc);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    retire     = 1'($urandom_range(0, 1));
    step();
    rst    = 1'b0;
    retire = 1'b0;
    m_pc    = RESET_PC;
    m_instr = NOP;
    m_fault = 1'b0;
    m_cause = 2'b00;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    // Boot cycle: an ack here must not be captured.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, RESET_PC);
    chk("boot_instr", instr, NOP);
    chk("boot_valid", 32'(instr_valid), 32'd0);
  endtask

  // Hold off the ack for wait_n cycles, then return word (or time out).
  task automatic fetch(input int unsigned wait_n, input logic [31:0] word);
    for (int unsigned i = 0; i < wait_n; i++) begin
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, m_pc);
      imem_ack = 1'b0;
      retire   = 1'($urandom_range(0, 1));
      step();
      retire = 1'b0;
      if (i == ACK_TIMEOUT - 1) begin
        m_fault = 1'b1;
        m_cause = 2'b01;
        check_fault("timeout");
        return;
      end
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_instr    = word;
    check_hold("fetched");
  endtask

  task automatic idle_hold(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      imem_ack      = 1'($urandom_range(0, 1));
      imem_rdata    = $urandom;
      PCSrc         = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      step();
      imem_ack = 1'b0;
      check_hold("hold_idle");
    end
  endtask

  task automatic do_retire(input logic src, input logic jsrc,
                           input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] tgt;
    if (!src)      tgt = m_pc + 32'd4;
    else if (jsrc) tgt = {jt[31:1], 1'b0};
    else           tgt = bt;
    PCSrc         = src;
    JumpSrc       = jsrc;
    branch_target = bt;
    jalr_target   = jt;
    retire        = 1'b1;
    step();
    retire = 1'b0;
    if (tgt[1:0] != 2'b00) begin
      m_fault = 1'b1;
      m_cause = 2'b10;
      check_fault("misalign");
    end else begin
      m_pc = tgt;
      chk("ret_pc", pc, m_pc);
      chk("ret_pc4", pc_plus4, m_pc + 32'd4);
      chk("ret_addr", imem_addr, m_pc);
      chk("ret_req", 32'(imem_req), 32'd1);
      chk("ret_valid", 32'(instr_valid), 32'd0);
      chk("ret_fault", 32'(fault), 32'd0);
    end
  endtask

  task automatic fault_linger(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      imem_ack      = 1'($urandom_range(0, 1));
      retire        = 1'($urandom_range(0, 1));
      PCSrc         = 1'($urandom_range(0, 1));
      branch_target = $urandom & 32'hFFFF_FFFC;
      step();
      imem_ack = 1'b0;
      retire   = 1'b0;
      check_fault("fault_sticky");
    end
  endtask

  initial begin
    logic [31:0] r, bt, jt;
    int unsigned w;
    rst = 1'b1; PCSrc = 1'b0; JumpSrc = 1'b0; retire = 1'b0;
    branch_target = '0; jalr_target = '0; imem_ack = 1'b0; imem_rdata = '0;
    m_pc = RESET_PC; m_instr = NOP; m_fault = 1'b0; m_cause = 2'b00;

    do_reset();
    fetch(0, 32'h0050_0093);
    chk("first_instr", instr, 32'h0050_0093);
    idle_hold(2);
    do_retire(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    fetch(2, $urandom);
    do_retire(1'b0, 1'b0, 32'h0, 32'h0);
    chk("seq_addr_14", imem_addr, 32'h0000_0014);
    fetch(1, $urandom);
    do_retire(1'b1, 1'b1, 32'h0000_0203, 32'h0000_0101);
    chk("jalr_pc_100", pc, 32'h0000_0100);
    fetch(0, $urandom);
    do_retire(1'b1, 1'b0, 32'h0000_0102, 32'h0);
    chk("br_mis_cause", 32'(fault_cause), 32'd2);
    fault_linger(3);

    do_reset();
    fetch(ACK_TIMEOUT, $urandom);
    chk("to_cause", 32'(fault_cause), 32'd1);
    fault_linger(2);
    do_reset();
    chk("post_to_fault", 32'(fault), 32'd0);

    // Ack on the very last allowed cycle wins over the timeout.
    fetch(ACK_TIMEOUT - 1, 32'h1234_5678);
    do_retire(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    fetch(0, $urandom);
    chk("wrap_pc4", pc_plus4, 32'h0000_0000);
    do_retire(1'b0, 1'b1, 32'h3, 32'h3);
    chk("wrap_pc", pc, 32'h0000_0000);

    // Reset coinciding with an ack discards the returned word.
    imem_ack   = 1'b1;
    imem_rdata = 32'hABCD_1234;
    rst        = 1'b1;
    step();
    rst      = 1'b0;
    imem_ack = 1'b0;
    m_pc = RESET_PC; m_instr = NOP; m_fault = 1'b0; m_cause = 2'b00;
    chk("rstack_instr", instr, NOP);
    chk("rstack_valid", 32'(instr_valid), 32'd0);
    chk("rstack_req", 32'(imem_req), 32'd0);
    chk("rstack_pc", pc, RESET_PC);
    step();
    chk("rstack_fetch", 32'(imem_req), 32'd1);

    for (int t = 0; t < 80; t++) begin
      w = ($urandom_range(0, 9) == 0) ? ACK_TIMEOUT + $urandom_range(0, 2)
                                      : $urandom_range(0, 5);
      fetch(w, $urandom);
      if (m_fault) begin
        fault_linger(1);
        do_reset();
        continue;
      end
      idle_hold($urandom_range(0, 2));
      r  = $urandom;
      bt = (r & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      r  = $urandom;
      jt = (r & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1))
         | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      do_retire(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bt, jt);
      if (m_fault) begin
        fault_linger(1);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
